// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand stage, alu_seq and writeback.
// The master drives operands and accepts results; the slave is the ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, signed/unsigned compare and a
// WIDTH-cycle shift-add multiplier; one operation in flight at a time.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpNot  = 4'd2;
  localparam logic [3:0] OpAnd  = 4'd3;
  localparam logic [3:0] OpOr   = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSlt  = 4'd6;
  localparam logic [3:0] OpSltu = 4'd7;
  localparam logic [3:0] OpEq   = 4'd8;
  localparam logic [3:0] OpMul  = 4'd9;

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH:0]   OneExt  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Zeros   = '0;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic [WIDTH:0]     sum_ext;

  // Single-cycle ops, evaluated on the operands presented at accept.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    sum_ext   = '0;
    case (bus.op)
      OpAdd: begin
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        sum_ext   = {1'b0, bus.a} + {1'b0, ~bus.b} + OneExt;
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpNot:  alu_res = ~bus.a;
      OpAnd:  alu_res = bus.a & bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpXor:  alu_res = bus.a ^ bus.b;
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OpEq:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.op == OpMul) begin
            acc_d    = '0;
            mcand_d  = {Zeros, bus.a};
            mplier_d = bus.b;
            cnt_d    = '0;
            state_d  = StBusy;
          end else begin
            result_d   = alu_res;
            zero_d     = (alu_res == Zeros);
            carry_d    = alu_carry;
            overflow_d = alu_ovf;
            state_d    = StDone;
          end
        end
      end
      StBusy: begin
        // One partial product per cycle, multiplier LSB first.
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d   = acc_d[WIDTH-1:0];
          zero_d     = (acc_d[WIDTH-1:0] == Zeros);
          carry_d    = |acc_d[2*WIDTH-1:WIDTH];
          overflow_d = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  int   lat;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                       input logic cin_v);
    bus.op       = op_v;
    bus.a        = a_v;
    bus.b        = b_v;
    bus.cin      = cin_v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = 8'hA5;
    bus.b        = 8'h5A;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] r, input logic z, input logic c,
                            input logic v);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_res"}, {24'd0, bus.result}, {24'd0, r});
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
    check({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, c});
    check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, v});
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 4'd0;
    bus.a         = 8'd0;
    bus.b         = 8'd0;
    bus.cin       = 1'b0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_flags", {29'd0, bus.zero, bus.carry, bus.overflow}, 32'd0);
    rst = 1'b0;

    issue(4'd0, 8'h7F, 8'h01, 1'b0); expect_res("add_ovf", 8'h80, 0, 0, 1); release_out();
    issue(4'd0, 8'hFF, 8'h00, 1'b1); expect_res("add_cin", 8'h00, 1, 1, 0); release_out();
    issue(4'd1, 8'h05, 8'h05, 1'b0); expect_res("sub_eq", 8'h00, 1, 1, 0); release_out();
    issue(4'd1, 8'h00, 8'h01, 1'b0); expect_res("sub_borrow", 8'hFF, 0, 0, 0); release_out();
    issue(4'd1, 8'h80, 8'h01, 1'b0); expect_res("sub_ovf", 8'h7F, 0, 1, 1); release_out();
    issue(4'd6, 8'hFF, 8'h01, 1'b0); expect_res("slt", 8'h01, 0, 0, 0); release_out();
    issue(4'd7, 8'hFF, 8'h01, 1'b0); expect_res("sltu", 8'h00, 1, 0, 0); release_out();
    issue(4'd8, 8'h3C, 8'h3C, 1'b0); expect_res("eq", 8'h01, 0, 0, 0); release_out();
    issue(4'd2, 8'h0F, 8'h00, 1'b0); expect_res("not", 8'hF0, 0, 0, 0); release_out();
    issue(4'd3, 8'hCC, 8'hAA, 1'b0); expect_res("and", 8'h88, 0, 0, 0); release_out();
    issue(4'd4, 8'hCC, 8'hAA, 1'b0); expect_res("or", 8'hEE, 0, 0, 0); release_out();
    issue(4'd5, 8'hF0, 8'hFF, 1'b0); expect_res("xor", 8'h0F, 0, 0, 0); release_out();
    issue(4'd12, 8'h12, 8'h34, 1'b1); expect_res("undef", 8'h00, 1, 0, 0); release_out();

    // Multiplier latency: out_valid must appear exactly 9 cycles after accept.
    issue(4'd9, 8'h0D, 8'h0B, 1'b0);
    check("mul_busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("mul_latency", lat, 32'd9);
    expect_res("mul", 8'h8F, 0, 0, 0); release_out();
    issue(4'd9, 8'h10, 8'h10, 1'b0);
    repeat (8) tick();
    expect_res("mul_hi", 8'h00, 1, 1, 0); release_out();

    // Backpressure: held result, no accepts while DONE.
    issue(4'd0, 8'h03, 8'h04, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.op = 4'd1; bus.a = 8'hFF; bus.b = 8'h01; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      expect_res("bp_hold", 8'h07, 0, 0, 0);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.op = 4'd0; bus.a = 8'h01; bus.b = 8'h01; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

    // Reset during MUL BUSY cycle 3.
    issue(4'd9, 8'h0D, 8'h0B, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_result", {24'd0, bus.result}, 32'd0);
    check("mrst_flags", {29'd0, bus.zero, bus.carry, bus.overflow}, 32'd0);
    issue(4'd0, 8'h01, 8'h01, 1'b0); expect_res("post_rst_add", 8'h02, 0, 0, 0); release_out();

    // Accept coincident with reset is dropped.
    rst = 1'b1;
    issue(4'd0, 8'h05, 8'h06, 1'b0);
    rst = 1'b0;
    check("rst_drop_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    check("rst_drop_valid2", {31'd0, bus.out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
